lod_scan: RTL
=============

LOD_SCAN -- requirements
Module: lod_scan

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the sign-magnitude fixed-point word width, with bit SIZE-1 as sign and SIZE/2 fraction bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port In_valid, input, 1 bit: upstream word valid.
REQ-005 The block SHALL have port In_ready, output, 1 bit: block can accept a word.
REQ-006 The block SHALL have port In, input, SIZE bits: sign-magnitude operand.
REQ-007 The block SHALL have port Out_valid, output, 1 bit: result valid to the downstream shift stage.
REQ-008 The block SHALL have port Out_ready, input, 1 bit: downstream accepts result.
REQ-009 The block SHALL have port Data_out, output, SIZE bits: captured copy of the accepted In.
REQ-010 The block SHALL have port Bit_shift, output, $clog2(SIZE) bits: index of the leading one in magnitude bits [SIZE-2:0].
REQ-011 The block SHALL have port Check, output, 1 bit: 1 if magnitude is nonzero.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SCAN, DONE.
REQ-013 In IDLE, In_ready SHALL be 1, except in the first cycle after reset release (see REQ-024).
- Handshake: In_valid && In_ready at a clock edge.
- On handshake, the block SHALL capture In into Data_out, load scan index = SIZE-2, set In_ready=0, and go to SCAN.
REQ-014 In SCAN, the block SHALL examine captured bit [index] once per cycle, scanning downward; the sign bit is never examined.
REQ-015 If bit [index]=1 in SCAN, the block SHALL set Bit_shift=index, Check=1, and go to DONE.
REQ-016 If bit [index]=0 and index=0 in SCAN, the block SHALL set Bit_shift=0, Check=0, and go to DONE.
REQ-017 If bit [index]=0 and index>0 in SCAN, the block SHALL decrement index and stay in SCAN; index SHALL NOT wrap below 0.
REQ-018 Latency from the handshake edge to the edge asserting Out_valid SHALL be SIZE-1-p cycles for leading one at p.
- Zero magnitude: SIZE-1 cycles.
- Minimum 1 (p=SIZE-2); maximum SIZE-1.
REQ-019 In DONE, Out_valid SHALL be 1, and Data_out, Bit_shift and Check SHALL stay stable until Out_valid && Out_ready.
REQ-020 On an edge with Out_valid && Out_ready, the block SHALL clear Out_valid, set In_ready=1, and return to IDLE.
- No new word is accepted on that same edge (one idle cycle between results).
REQ-021 In_valid SHALL be ignored, and In not sampled, in SCAN and DONE.
REQ-022 Negative zero (sign=1, magnitude=0) SHALL give Check=0 and Bit_shift=0, with Data_out preserving the sign bit.
REQ-023 Out_ready while Out_valid=0 SHALL have no effect.

Reset
REQ-024 On any edge with rst_n=0, including mid-SCAN and mid-DONE, the block SHALL:
- set state=IDLE;
- clear In_ready, Out_valid, Data_out, Bit_shift, Check and index to 0.
REQ-025 In_ready SHALL rise to 1 on the first edge with rst_n=1, and no handshake SHALL occur before that.

Verification (SIZE=32)
REQ-026 Scenario: accept In=0x4000_0000 -> Out_valid 1 cycle later, Bit_shift=30, Check=1, Data_out=0x4000_0000.
REQ-027 Scenario: accept In=0x0001_8000 -> Out_valid 15 cycles later, Bit_shift=16, Check=1.
REQ-028 Scenario: accept In=0x8000_0000 -> Out_valid 31 cycles later, Bit_shift=0, Check=0, Data_out=0x8000_0000.
REQ-029 Scenario: accept In=0x8000_0001 -> Out_valid 31 cycles later, Bit_shift=0, Check=1.
REQ-030 Scenario: hold Out_ready=0 for 5 cycles in DONE while In_valid=1 with a changing In ->
- outputs stable and In_ready=0 throughout;
- on Out_ready=1, Out_valid falls the next edge and In_ready=1.
REQ-031 Scenario: drive rst_n=0 for 1 cycle mid-SCAN ->
- next cycle all outputs 0 and no Out_valid pulse;
- In_ready=1 one edge after rst_n returns high.

Source files
------------

// File: rtl/lod_scan_if.sv
// Handshake bundle between an upstream word source, the leading-one scanner
// and the downstream shift stage.
interface lod_scan_if #(
  parameter int SIZE = 32
);
  localparam int IW = $clog2(SIZE);

  logic            In_valid;
  logic            In_ready;
  logic [SIZE-1:0] In;
  logic            Out_valid;
  logic            Out_ready;
  logic [SIZE-1:0] Data_out;
  logic [IW-1:0]   Bit_shift;
  logic            Check;

  modport master (
    output In_valid, In, Out_ready,
    input  In_ready, Out_valid, Data_out, Bit_shift, Check
  );

  modport slave (
    input  In_valid, In, Out_ready,
    output In_ready, Out_valid, Data_out, Bit_shift, Check
  );
endinterface

// File: rtl/lod_scan.sv
// Serial leading-one detector for a sign-magnitude word: scans the magnitude
// bits downward one per cycle and reports the leading-one index.
module lod_scan #(
  parameter int SIZE = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  lod_scan_if.slave  bus
);
  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] IDX_TOP = IW'(SIZE - 2);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_nx;
  logic            in_ready, in_ready_nx;
  logic            out_valid, out_valid_nx;
  logic            check, check_nx;
  logic [SIZE-1:0] data, data_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [IW-1:0]   bit_shift, bit_shift_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      check     <= 1'b0;
      data      <= '0;
      idx       <= '0;
      bit_shift <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      check     <= check_nx;
      data      <= data_nx;
      idx       <= idx_nx;
      bit_shift <= bit_shift_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    in_ready_nx  = in_ready;
    out_valid_nx = out_valid;
    check_nx     = check;
    data_nx      = data;
    idx_nx       = idx;
    bit_shift_nx = bit_shift;
    case (state)
      IDLE: begin
        // in_ready is still 0 on the first cycle out of reset, so no handshake there
        in_ready_nx = 1'b1;
        if (bus.In_valid && in_ready) begin
          data_nx     = bus.In;
          idx_nx      = IDX_TOP;
          in_ready_nx = 1'b0;
          state_nx    = SCAN;
        end
      end
      SCAN: begin
        if (data[idx]) begin
          bit_shift_nx = idx;
          check_nx     = 1'b1;
          out_valid_nx = 1'b1;
          state_nx     = DONE;
        end else if (idx == '0) begin
          bit_shift_nx = '0;
          check_nx     = 1'b0;
          out_valid_nx = 1'b1;
          state_nx     = DONE;
        end else begin
          idx_nx = idx - IW'(1);
        end
      end
      DONE: begin
        if (bus.Out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = out_valid;
  assign bus.Data_out  = data;
  assign bus.Bit_shift = bit_shift;
  assign bus.Check     = check;
endmodule
